// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event decoder.
// The walk hold-off window is only compiled in when WALK_HOLDOFF_EN is defined.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } walk_state_t;

    localparam int HOLDOFF_CYCLES_DEF = 16;
    localparam int CNT_W_DEF          = 8;

    // Wide enough to hold the load value itself, not just values below it.
    function automatic int holdoff_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one debounced button level: combinational event
// for local consumers plus a registered one-cycle pulse.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic edge_evt,
    output logic pulse
);

    logic prev;

    // prev resets high so a button held through reset produces no event.
    assign edge_evt = level & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= edge_evt;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Button events for the traffic controller: reset/reprogram pulses and a latched walk request.
// Optional walk hold-off after acknowledge is enabled with `define WALK_HOLDOFF_EN.
//
// state   | meaning
// IDLE    | no walk request outstanding, presses accepted
// PENDING | walk request latched, waiting for walk_ack
// HOLDOFF | post-ack window, presses ignored (WALK_HOLDOFF_EN only)
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             reset_db_in,
    input  logic             walkRequest_db_in,
    input  logic             reprogram_db_in,
    input  logic             walk_ack,
    output logic             reset_pulse,
    output logic             reprogram_pulse,
    output logic             walk_pending,
    output logic [CNT_W-1:0] walk_count
);

    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be >= 1");
    end

    logic reset_evt;
    logic walk_evt;
    logic reprogram_evt_unused;
    logic walk_pulse_unused;

    edge_pulse u_reset_edge (
        .clk      (clk),
        .rst_n    (sys_reset),
        .level    (reset_db_in),
        .edge_evt (reset_evt),
        .pulse    (reset_pulse)
    );

    edge_pulse u_walk_edge (
        .clk      (clk),
        .rst_n    (sys_reset),
        .level    (walkRequest_db_in),
        .edge_evt (walk_evt),
        .pulse    (walk_pulse_unused)
    );

    edge_pulse u_reprogram_edge (
        .clk      (clk),
        .rst_n    (sys_reset),
        .level    (reprogram_db_in),
        .edge_evt (reprogram_evt_unused),
        .pulse    (reprogram_pulse)
    );

    walk_state_t state;

`ifdef WALK_HOLDOFF_EN
    localparam int              HOLD_W    = holdoff_cnt_w(HOLDOFF_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state        <= IDLE;
            walk_pending <= 1'b0;
            walk_count   <= '0;
            hold_cnt     <= '0;
        end else if (reset_evt) begin
            // Reset button overrides any walk activity but keeps the press tally.
            state        <= IDLE;
            walk_pending <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (walk_evt) begin
                        state        <= PENDING;
                        walk_pending <= 1'b1;
                        if (walk_count != '1) walk_count <= walk_count + 1'b1;
                    end
                end
                PENDING: begin
                    if (walk_ack) begin
                        state        <= HOLDOFF;
                        walk_pending <= 1'b0;
                        hold_cnt     <= HOLD_LOAD;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    walk_pending <= 1'b0;
                    hold_cnt     <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state        <= IDLE;
            walk_pending <= 1'b0;
            walk_count   <= '0;
        end else if (reset_evt) begin
            state        <= IDLE;
            walk_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (walk_evt) begin
                        state        <= PENDING;
                        walk_pending <= 1'b1;
                        if (walk_count != '1) walk_count <= walk_count + 1'b1;
                    end
                end
                PENDING: begin
                    // A press coinciding with the ack is dropped, not re-latched.
                    if (walk_ack) begin
                        state        <= IDLE;
                        walk_pending <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    walk_pending <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder (HOLDOFF_CYCLES=4, CNT_W=2).
module tb_button_event_decoder;

    localparam int HOLD  = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef WALK_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic sys_reset = 1'b0;
    logic reset_db_in = 1'b0;
    logic walkRequest_db_in = 1'b0;
    logic reprogram_db_in = 1'b0;
    logic walk_ack = 1'b0;
    logic reset_pulse;
    logic reprogram_pulse;
    logic walk_pending;
    logic [CNT_W-1:0] walk_count;

    int tests = 0;
    int fails = 0;

    button_event_decoder #(.HOLDOFF_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .sys_reset         (sys_reset),
        .reset_db_in       (reset_db_in),
        .walkRequest_db_in (walkRequest_db_in),
        .reprogram_db_in   (reprogram_db_in),
        .walk_ack          (walk_ack),
        .reset_pulse       (reset_pulse),
        .reprogram_pulse   (reprogram_pulse),
        .walk_pending      (walk_pending),
        .walk_count        (walk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: last seen levels, a pending flag, remaining ignore window, press tally.
    bit m_lvl_r, m_lvl_w, m_lvl_p;
    bit m_rst_pulse, m_rp_pulse, m_pending;
    int m_hold, m_count;

    always @(posedge clk or negedge sys_reset) begin
        bit er, ew, ep;
        if (!sys_reset) begin
            m_lvl_r = 1; m_lvl_w = 1; m_lvl_p = 1;
            m_rst_pulse = 0; m_rp_pulse = 0; m_pending = 0;
            m_hold = 0; m_count = 0;
        end else begin
            er = reset_db_in && !m_lvl_r;
            ew = walkRequest_db_in && !m_lvl_w;
            ep = reprogram_db_in && !m_lvl_p;
            m_lvl_r = reset_db_in;
            m_lvl_w = walkRequest_db_in;
            m_lvl_p = reprogram_db_in;
            m_rst_pulse = er;
            m_rp_pulse  = ep;
            if (er) begin
                m_pending = 0;
                m_hold = 0;
            end else if (m_pending) begin
                if (walk_ack) begin
                    m_pending = 0;
                    m_hold = HOLD_EN ? HOLD : 0;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (ew) begin
                m_pending = 1;
                if (m_count < CMAX) m_count++;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_reset_pulse", reset_pulse, m_rst_pulse);
        chk("model_reprogram_pulse", reprogram_pulse, m_rp_pulse);
        chk("model_walk_pending", walk_pending, m_pending);
        chk("model_walk_count", walk_count, m_count);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int highs;
        // Reset with walk held high.
        walkRequest_db_in = 1'b1;
        tick(3);
        chk("rst_walk_pending", walk_pending, 0);
        chk("rst_walk_count", walk_count, 0);
        chk("rst_reset_pulse", reset_pulse, 0);
        chk("rst_reprogram_pulse", reprogram_pulse, 0);
        sys_reset = 1'b1;
        tick(10);
        chk("held_walk_pending", walk_pending, 0);
        chk("held_walk_count", walk_count, 0);
        walkRequest_db_in = 1'b0; tick();
        walkRequest_db_in = 1'b1; tick();
        chk("press_walk_pending", walk_pending, 1);
        chk("press_walk_count", walk_count, 1);

        // Presses absorbed while pending, then ack.
        walkRequest_db_in = 1'b0; tick();
        walkRequest_db_in = 1'b1; tick();
        walkRequest_db_in = 1'b0; tick();
        walkRequest_db_in = 1'b1; tick();
        chk("absorb_walk_count", walk_count, 1);
        walk_ack = 1'b1; walkRequest_db_in = 1'b0; tick();
        walk_ack = 1'b0;
        chk("ack_walk_pending", walk_pending, 0);
        chk("ack_walk_count", walk_count, 1);

        // Presses at ack+1 and ack+3 (ignored in hold-off), ack+5 (accepted).
        walkRequest_db_in = 1'b1; tick();
        walkRequest_db_in = 1'b0; tick();
        walkRequest_db_in = 1'b1; tick();
        chk("holdoff_pending", walk_pending, HOLD_EN ? 0 : 1);
        walkRequest_db_in = 1'b0; tick();
        walkRequest_db_in = 1'b1; tick();
        chk("after_holdoff_pending", walk_pending, 1);
        chk("after_holdoff_count", walk_count, 2);

        // Reprogram held for 50 cycles.
        reprogram_db_in = 1'b1;
        highs = 0;
        tick();
        chk("reprogram_first", reprogram_pulse, 1);
        for (int i = 0; i < 50; i++) begin
            if (reprogram_pulse) highs++;
            tick();
        end
        chk("reprogram_pulse_cycles", highs, 1);
        reprogram_db_in = 1'b0;

        // Walk and reset-button edges together from IDLE.
        walk_ack = 1'b1; tick();
        walk_ack = 1'b0; walkRequest_db_in = 1'b0; reset_db_in = 1'b0;
        tick(6);
        walkRequest_db_in = 1'b1; reset_db_in = 1'b1; tick();
        chk("rstprio_pending", walk_pending, 0);
        chk("rstprio_count", walk_count, 2);
        chk("rstprio_reset_pulse", reset_pulse, 1);
        tick();
        chk("rstprio_pulse_end", reset_pulse, 0);
        walkRequest_db_in = 1'b0; reset_db_in = 1'b0;

        // Saturation from a fresh reset.
        sys_reset = 1'b0; tick();
        sys_reset = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            walkRequest_db_in = 1'b0; tick();
            walkRequest_db_in = 1'b1; tick();
            walkRequest_db_in = 1'b0; walk_ack = 1'b1; tick();
            walk_ack = 1'b0; tick(6);
            chk("sat_count", walk_count, (i + 1 > 3) ? 3 : i + 1);
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                sys_reset = 1'b0; tick();
                sys_reset = 1'b1;
            end
            walkRequest_db_in = 1'($urandom_range(0, 1));
            reset_db_in       = ($urandom_range(0, 15) == 0);
            reprogram_db_in   = 1'($urandom_range(0, 1));
            walk_ack          = ($urandom_range(0, 3) == 0);
            tick();
        end
        walkRequest_db_in = 1'b0; reset_db_in = 1'b0; reprogram_db_in = 1'b0; walk_ack = 1'b0;
        tick(8);

        // Async reset while pending, checked between clock edges.
        walkRequest_db_in = 1'b1; tick();
        chk("async_pre_pending", walk_pending, 1);
        @(posedge clk);
        #3 sys_reset = 1'b0;
        #1;
        chk("async_pending", walk_pending, 0);
        chk("async_count", walk_count, 0);
        tick();
        sys_reset = 1'b1;
        walkRequest_db_in = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
